// File: rtl/rbs32_serial_pkg.sv
// Shared constants and FSM encoding for the serial ripple-borrow subtractor.
package rbs_pkg;
  localparam int WIDTH = 32;
  localparam int SLICE = 4;
  localparam int N     = WIDTH / SLICE;
  localparam int CW    = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/rbs32_serial_if.sv
// Request/result bundle for rbs32_serial.
interface rbs32_serial_if;
  import rbs_pkg::*;

  // Handshake: start is a request that is taken on a rising edge only while busy=0
  // (busy acts as an inverted ready); done pulses for one cycle when d/bout/v update.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] d;
  logic             bout;
  logic             v;
  logic             busy;
  logic             done;

  modport master (output start, a, b, bin, input d, bout, v, busy, done);
  modport slave  (input start, a, b, bin, output d, bout, v, busy, done);
endinterface

// File: rtl/rbs32_serial_sub_slice.sv
// Combinational SLICE-bit ripple-borrow subtractor: d = a - b - bin.
module sub_slice
  import rbs_pkg::*;
(
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             bin,
  output logic [SLICE-1:0] d,
  output logic             bout
);
  logic [SLICE:0] chain;

  always_comb begin
    chain    = '0;
    d        = '0;
    chain[0] = bin;
    for (int i = 0; i < SLICE; i++) begin
      d[i]       = a[i] ^ b[i] ^ chain[i];
      chain[i+1] = (~a[i] & b[i]) | (~a[i] & chain[i]) | (b[i] & chain[i]);
    end
  end

  assign bout = chain[SLICE];
endmodule

// File: rtl/rbs32_serial.sv
// Serial 32-bit subtractor: one SLICE-bit slice per clock, LSB slice first,
// borrow held in a register between slices.
module rbs32_serial
  import rbs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rbs32_serial_if.slave  bus,
  output state_t         state_dbg
);
  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_next;
  logic             brw_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] d_q;
  logic             bout_q, v_q, busy_q, done_q;

  logic [SLICE-1:0] a_s, b_s, d_s;
  logic             bout_s;
  logic             last;

  assign a_s  = a_q[SLICE*int'(cnt_q) +: SLICE];
  assign b_s  = b_q[SLICE*int'(cnt_q) +: SLICE];
  assign last = (cnt_q == CW'(N-1));

  sub_slice u_slice (
    .a    (a_s),
    .b    (b_s),
    .bin  (brw_q),
    .d    (d_s),
    .bout (bout_s)
  );

  // Result including the slice being computed this cycle, so completion can
  // publish the full value on the same edge as the last slice.
  always_comb begin
    res_next = res_q;
    res_next[SLICE*int'(cnt_q) +: SLICE] = d_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      v_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            brw_q  <= bus.bin;
            res_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          res_q <= res_next;
          brw_q <= bout_s;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            d_q    <= res_next;
            bout_q <= bout_s;
            v_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.d     = d_q;
  assign bus.bout  = bout_q;
  assign bus.v     = v_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign state_dbg = state;
endmodule

// File: tb/tb_rbs32_serial.sv
// Directed self-checking bench for rbs32_serial.
module tb_rbs32_serial;
  import rbs_pkg::*;

  logic   clk;
  logic   rst;
  state_t state_dbg;
  int     n_checks;
  int     n_fail;
  logic [WIDTH+1:0] exp_q[$];

  rbs32_serial_if bus();

  rbs32_serial dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // driver: one operation, result compared through the expected queue
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                       input logic [31:0] ed, input logic eb, input logic ev);
    logic [WIDTH+1:0] e;
    logic [31:0]      prev_d;
    int               cyc;
    exp_q.push_back({eb, ev, ed});
    prev_d    = bus.d;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bin   = ~bin;
    chk("busy_after_e0", 32'(bus.busy), 32'd1);
    chk("state_run", 32'(state_dbg), 32'(RUN));
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (bus.done) break;
      chk("busy_mid", 32'(bus.busy), 32'd1);
      chk("d_hold_mid", bus.d, prev_d);
    end
    chk("latency", 32'(cyc), 32'(N));
    e = exp_q.pop_front();
    chk("done", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk("d", bus.d, e[31:0]);
    chk("bout", 32'(bus.bout), 32'(e[33]));
    chk("v", 32'(bus.v), 32'(e[32]));
    tick();
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("d_held", bus.d, e[31:0]);
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    tick();
    tick();
    chk("rst_d", bus.d, 32'h0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_v", 32'(bus.v), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b0;
    tick();
    chk("idle_no_start", 32'(bus.busy), 32'd0);

    do_op(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0);
    do_op(32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1);
    do_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1);
    do_op(32'h10000000, 32'h0FFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b0);
    do_op(32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op(32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0);
    do_op(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 1'b0, 1'b1);

    // START during RUN ignored; START at EN ignored; START at EN+1 accepted
    bus.a = 32'd9; bus.b = 32'd4; bus.bin = 1'b0; bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick(); tick();                           // E1, E2
    bus.a = 32'd1; bus.b = 32'd7; bus.start = 1'b1;
    tick();                                   // E3
    bus.start = 1'b0;
    chk("ign_busy_e3", 32'(bus.busy), 32'd1);
    for (int i = 4; i < 8; i++) begin
      tick();
      chk("ign_no_done", 32'(bus.done), 32'd0);
    end
    bus.a = 32'h30; bus.b = 32'h10; bus.start = 1'b1;
    tick();                                   // E8
    chk("ign_done", 32'(bus.done), 32'd1);
    chk("ign_d", bus.d, 32'd5);
    chk("ign_busy_e8", 32'(bus.busy), 32'd0);
    tick();                                   // E9 accepts
    bus.start = 1'b0;
    chk("reaccept_busy", 32'(bus.busy), 32'd1);
    chk("reaccept_done_low", 32'(bus.done), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    chk("reaccept_no_early", 32'(bus.done), 32'd0);
    tick();
    chk("reaccept_done", 32'(bus.done), 32'd1);
    chk("reaccept_d", bus.d, 32'h20);

    // reset in the middle of an operation aborts it
    bus.a = 32'h55; bus.b = 32'h11; bus.start = 1'b1;
    tick();                                   // E0
    bus.start = 1'b0;
    tick(); tick(); tick();                   // E1..E3
    rst = 1'b1;
    tick();                                   // E4
    rst = 1'b0;
    chk("abort_d", bus.d, 32'h0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bout", 32'(bus.bout), 32'd0);
    chk("abort_v", 32'(bus.v), 32'd0);
    chk("abort_state", 32'(state_dbg), 32'(IDLE));
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus.done) seen++;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    do_op(32'h00000020, 32'h00000010, 1'b0, 32'h00000010, 1'b0, 1'b0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
